// File: rtl/bsearch_guesser_pkg.sv
// Shared types and helpers for the binary-search guesser.
// Used by the guesser and by anything that drives its comparator.
package bsearch_guesser_pkg;

  localparam int WIDTH_DEF = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Flags arrive packed as {E, L, G}
  function automatic logic onehot3(input logic [2:0] f);
    return (f == 3'b100) ||
           (f == 3'b010) ||
           (f == 3'b001);
  endfunction

endpackage

// File: rtl/bsearch_guesser.sv
// Binary-search engine that recovers a hidden operand from a
// magnitude comparator's one-hot E/L/G result.
module bsearch_guesser
  import bsearch_guesser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             E,
  input  logic             L,
  input  logic             G,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] found,
  output logic [WIDTH:0]   steps,
  output logic             err
);

  localparam int RW = WIDTH + 1;
  localparam logic [RW-1:0] TOP = RW'((1 << WIDTH) - 1);

  state_t state;
  state_t state_nxt;

  logic [RW-1:0]    lo;
  logic [RW-1:0]    hi;
  logic [RW-1:0]    lo_nxt;
  logic [RW-1:0]    hi_nxt;
  logic [RW-1:0]    mid;
  logic [RW-1:0]    mid_nxt;
  logic [WIDTH-1:0] guess_nxt;
  logic [WIDTH-1:0] found_nxt;
  logic [WIDTH:0]   steps_nxt;
  logic             err_nxt;
  logic             busy_nxt;
  logic             done_nxt;
  logic [2:0]       flags;
  logic             flags_ok;

  // Range is one bit wider than the operand, so the sum never wraps
  function automatic logic [RW-1:0] midpoint(
    input logic [RW-1:0] a,
    input logic [RW-1:0] b
  );
    return RW'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  assign flags    = {E, L, G};
  assign flags_ok = onehot3(flags);
  assign mid      = midpoint(lo, hi);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (!flags_ok) begin
          state_nxt = DONE;
        end else begin
          unique case (1'b1)
            E: state_nxt = DONE;
            L: state_nxt = (mid > lo) ? SETTLE : DONE;
            G: state_nxt = (mid < hi) ? SETTLE : DONE;
            default: state_nxt = DONE;
          endcase
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    lo_nxt    = lo;
    hi_nxt    = hi;
    found_nxt = found;
    steps_nxt = steps;
    err_nxt   = err;
    guess_nxt = guess;
    mid_nxt   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          lo_nxt    = '0;
          hi_nxt    = TOP;
          found_nxt = '0;
          steps_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      SAMPLE: begin
        steps_nxt = steps + RW'(1);
        if (!flags_ok) begin
          err_nxt = 1'b1;
        end else begin
          unique case (1'b1)
            E: found_nxt = guess;
            L: begin
              if (mid > lo) begin
                hi_nxt = mid - RW'(1);
              end else begin
                err_nxt = 1'b1;
              end
            end
            G: begin
              if (mid < hi) begin
                lo_nxt = mid + RW'(1);
              end else begin
                err_nxt = 1'b1;
              end
            end
            default: err_nxt = 1'b1;
          endcase
        end
      end
      default: begin
      end
    endcase
    // Guess is registered on entry to SETTLE so it is stable all cycle
    if (state_nxt == SETTLE) begin
      mid_nxt   = midpoint(lo_nxt, hi_nxt);
      guess_nxt = mid_nxt[WIDTH-1:0];
    end
    busy_nxt = (state_nxt == SETTLE) ||
               (state_nxt == SAMPLE);
    done_nxt = (state_nxt == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo    <= '0;
      hi    <= TOP;
      guess <= '0;
      found <= '0;
      steps <= '0;
      err   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      lo    <= lo_nxt;
      hi    <= hi_nxt;
      guess <= guess_nxt;
      found <= found_nxt;
      steps <= steps_nxt;
      err   <= err_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bsearch_guesser.sv
// Bench for bsearch_guesser: behavioural comparator, scoreboard
// of expected search results, and a done-triggered monitor.
module tb_bsearch_guesser;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic         E;
  logic         L;
  logic         G;
  logic [W-1:0] guess;
  logic         busy;
  logic         done;
  logic [W-1:0] found;
  logic [W:0]   steps;
  logic         err;

  logic [W-1:0] hidden = '0;
  int           mode = 0;

  always #5 clk = ~clk;

  // mode 1: E and L both asserted; mode 2: comparator always says L
  always_comb begin
    if (mode == 1) begin
      {E, L, G} = 3'b110;
    end else if (mode == 2) begin
      {E, L, G} = 3'b010;
    end else begin
      E = (hidden == guess);
      L = (hidden < guess);
      G = (hidden > guess);
    end
  end

  bsearch_guesser #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .start  (start),
    .E      (E),
    .L      (L),
    .G      (G),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .found  (found),
    .steps  (steps),
    .err    (err)
  );

  typedef struct {
    int gs[4];
    int ng;
    int found;
    int steps;
    int err;
    int lat;
    int t0;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int   obs[$];
  int   cyc = 0;
  int   ph = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: guesses are recorded in each SETTLE cycle of a busy run
  always @(negedge clk) begin
    if (!resetn) begin
      obs.delete();
      ph = 0;
    end else begin
      if (busy) begin
        if (ph == 0) obs.push_back(int'(guess));
        ph = 1 - ph;
      end else begin
        ph = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          em = sb.pop_front();
          chk("n_guesses", obs.size(), em.ng);
          for (int i = 0; i < em.ng && i < obs.size(); i++)
            chk($sformatf("guess%0d", i), obs[i], em.gs[i]);
          chk("found", int'(found), em.found);
          chk("steps", int'(steps), em.steps);
          chk("err", int'(err), em.err);
          chk("done_cycle", cyc - em.t0 + 1, em.lat);
        end
        obs.delete();
      end
    end
  end

  task automatic kick(input int h, input int md, output int t0);
    @(negedge clk);
    hidden = W'(h);
    mode   = md;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic search(input int h, input int md,
                        input int gs[4], input int ng,
                        input int f, input int st,
                        input int e, input int lat);
    exp_t x;
    int   t0;
    kick(h, md, t0);
    x.gs    = gs;
    x.ng    = ng;
    x.found = f;
    x.steps = st;
    x.err   = e;
    x.lat   = lat;
    x.t0    = t0;
    sb.push_back(x);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_guess"}, int'(guess), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_steps"}, int'(steps), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  initial begin
    int t0;
    @(negedge clk);
    chk_reset_state("rst");
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    search(5, 0, '{3, 5, 0, 0}, 2, 5, 2, 0, 5);
    wait_done();
    search(7, 0, '{3, 5, 6, 7}, 4, 7, 4, 0, 9);
    wait_done();
    search(0, 0, '{3, 1, 0, 0}, 3, 0, 3, 0, 7);
    wait_done();
    search(2, 1, '{3, 0, 0, 0}, 1, 0, 1, 1, 3);
    wait_done();
    search(4, 2, '{3, 1, 0, 0}, 3, 0, 3, 1, 7);
    wait_done();

    // start pulses while busy and during DONE are ignored
    search(6, 0, '{3, 5, 6, 0}, 3, 6, 3, 0, 7);
    repeat (2) begin
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    wait_done();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("done_start_busy1", int'(busy), 0);
    @(negedge clk);
    chk("done_start_busy2", int'(busy), 0);
    chk("found_held", int'(found), 6);

    // reset during the second SETTLE
    kick(0, 0, t0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_guess", int'(guess), 1);
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_steps", int'(steps), 1);
    resetn = 1'b0;
    #1;
    chk_reset_state("midrst");
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    search(2, 0, '{3, 1, 2, 0}, 3, 2, 3, 0, 7);
    wait_done();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
